// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit result path between three sources,
// with a one-entry registered output stage and a valid/ready handshake.

module mux3to1_32bit (
  input  logic [1:0]  sel_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  output logic [31:0] y_o
);
  always_comb begin
    y_o = a_i;
    case (sel_i)
      2'b01:   y_o = b_i;
      2'b10:   y_o = c_i;
      default: y_o = a_i;
    endcase
  end
endmodule

// state | meaning
// EMPTY | output register holds no valid word
// FULL  | r_o holds a word awaiting rdy_i
module mux3_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       req_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             rdy_i,
  output logic [2:0]       gnt_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] r_o,
  output logic [1:0]       sel_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [1:0]       r_last;
  logic [1:0]       w_winner;
  logic             w_load;
  logic [WIDTH-1:0] w_mux;

  // Scan starts one past the last winner and wraps C -> A.
  always_comb begin
    w_winner = 2'b00;
    case (r_last)
      2'b00: begin
        if (req_i[1])      w_winner = 2'b01;
        else if (req_i[2]) w_winner = 2'b10;
        else               w_winner = 2'b00;
      end
      2'b01: begin
        if (req_i[2])      w_winner = 2'b10;
        else if (req_i[0]) w_winner = 2'b00;
        else               w_winner = 2'b01;
      end
      default: begin
        if (req_i[0])      w_winner = 2'b00;
        else if (req_i[1]) w_winner = 2'b01;
        else               w_winner = 2'b10;
      end
    endcase
  end

  generate
    if (WIDTH == 32) begin : g_mux32
      mux3to1_32bit u_mux (
        .sel_i (w_winner),
        .a_i   (a_i),
        .b_i   (b_i),
        .c_i   (c_i),
        .y_o   (w_mux)
      );
    end else begin : g_mux_gen
      always_comb begin
        w_mux = a_i;
        case (w_winner)
          2'b01:   w_mux = b_i;
          2'b10:   w_mux = c_i;
          default: w_mux = a_i;
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  // A reset cycle never grants, so the pulse cannot announce a discarded capture.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    gnt_o       = 3'b000;
    if (!rst_i) begin
      w_load = (|req_i) && ((r_state == EMPTY) || rdy_i);
      if (w_load) gnt_o[w_winner] = 1'b1;
      case (r_state)
        EMPTY: if (w_load) w_state_nxt = FULL;
        FULL:  if (rdy_i && !w_load) w_state_nxt = EMPTY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_sel  <= 2'b00;
      r_last <= 2'b10;
    end else if (w_load) begin
      r_data <= w_mux;
      r_sel  <= w_winner;
      r_last <= w_winner;
    end
  end

  assign vld_o = (r_state == FULL);
  assign r_o   = r_data;
  assign sel_o = r_sel;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: grant order, backpressure, drain and reset.

module tb_mux3_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  req_i;
  logic [31:0] a_i, b_i, c_i;
  logic        rdy_i;
  logic [2:0]  gnt_o;
  logic        vld_o;
  logic [31:0] r_o;
  logic [1:0]  sel_o;

  int checks = 0;
  int errors = 0;

  mux3_rr_arbiter #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .a_i   (a_i),
    .b_i   (b_i),
    .c_i   (c_i),
    .rdy_i (rdy_i),
    .gnt_o (gnt_o),
    .vld_o (vld_o),
    .r_o   (r_o),
    .sel_o (sel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] r, input logic [1:0] s);
    chk({tag, "_vld"}, {31'd0, vld_o}, {31'd0, v});
    chk({tag, "_r"},   r_o, r);
    chk({tag, "_sel"}, {30'd0, sel_o}, {30'd0, s});
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] g);
    #1;
    chk({tag, "_gnt"}, {29'd0, gnt_o}, {29'd0, g});
  endtask

  initial begin
    rst_i = 1'b1; req_i = 3'b000; rdy_i = 1'b0;
    a_i = 32'hAAAA_AAAA; b_i = 32'hBBBB_BBBB; c_i = 32'hCCCC_CCCC;
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0, 2'b00);
    rst_i = 1'b0;
    chk_gnt("reset_idle", 3'b000);

    // single A transfer, then drain
    req_i = 3'b001; rdy_i = 1'b1;
    chk_gnt("single_a", 3'b001);
    tick();
    chk_out("single_a", 1'b1, 32'hAAAA_AAAA, 2'b00);
    req_i = 3'b000;
    chk_gnt("drain", 3'b000);
    tick();
    chk_out("drain", 1'b0, 32'hAAAA_AAAA, 2'b00);

    // rdy_i while EMPTY changes nothing
    rdy_i = 1'b0;
    tick();
    rdy_i = 1'b1;
    tick();
    chk_out("empty_rdy", 1'b0, 32'hAAAA_AAAA, 2'b00);

    // fresh reset so the round-robin starts at A
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_i = 3'b111; rdy_i = 1'b1;
    chk_gnt("rr0", 3'b001);
    tick();
    chk_out("rr0", 1'b1, 32'hAAAA_AAAA, 2'b00);
    chk_gnt("rr1", 3'b010);
    tick();
    chk_out("rr1", 1'b1, 32'hBBBB_BBBB, 2'b01);
    chk_gnt("rr2", 3'b100);
    tick();
    chk_out("rr2", 1'b1, 32'hCCCC_CCCC, 2'b10);
    chk_gnt("rr3", 3'b001);
    tick();
    chk_out("rr3", 1'b1, 32'hAAAA_AAAA, 2'b00);

    // load B, then hold it under backpressure with A and C requesting
    chk_gnt("load_b", 3'b010);
    tick();
    chk_out("load_b", 1'b1, 32'hBBBB_BBBB, 2'b01);
    rdy_i = 1'b0; req_i = 3'b101;
    for (int i = 0; i < 4; i++) begin
      chk_gnt("stall", 3'b000);
      tick();
      chk_out("stall", 1'b1, 32'hBBBB_BBBB, 2'b01);
    end
    rdy_i = 1'b1;
    chk_gnt("release", 3'b100);
    tick();
    chk_out("release", 1'b1, 32'hCCCC_CCCC, 2'b10);

    // reset while FULL with all requesting
    req_i = 3'b111; rst_i = 1'b1;
    chk_gnt("rst_full", 3'b000);
    tick();
    chk_out("rst_full", 1'b0, 32'h0, 2'b00);
    rst_i = 1'b0;
    chk_gnt("post_rst", 3'b001);
    tick();
    chk_out("post_rst", 1'b1, 32'hAAAA_AAAA, 2'b00);

    // B withdraws before being granted; C wins instead
    rdy_i = 1'b0; req_i = 3'b110;
    chk_gnt("b_wait", 3'b000);
    tick();
    req_i = 3'b100; rdy_i = 1'b1;
    chk_gnt("b_drop", 3'b100);
    tick();
    chk_out("b_drop", 1'b1, 32'hCCCC_CCCC, 2'b10);
    req_i = 3'b000;
    tick();
    chk_out("final", 1'b0, 32'hCCCC_CCCC, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
